// File: rtl/bsg_pkg.sv
// Shared definitions for the bit-stream generator and the detector top level:
// FSM state encoding, default sizing constants and a width helper.
package bsg_pkg;

  localparam logic [1:0] BSG_IDLE  = 2'd0;
  localparam logic [1:0] BSG_SHIFT = 2'd1;
  localparam logic [1:0] BSG_DONE  = 2'd2;

  localparam int unsigned BSG_WIDTH = 16;
  localparam int unsigned BSG_DIV   = 4;
  localparam int unsigned BSG_LEN_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = BSG_IDLE,
    ST_SHIFT = BSG_SHIFT,
    ST_DONE  = BSG_DONE
  } bsg_state_e;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned bsg_cw(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/bit_tick_div.sv
// Divide-by-DIV counter with clear and enable; tc_o flags the last cycle of
// each DIV-cycle period so the caller can advance on the following edge.
module bit_tick_div
  import bsg_pkg::*;
#(
  parameter int unsigned DIV = BSG_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW     = bsg_cw(DIV);
  localparam logic [CW-1:0] TC_VAL = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE    = CW'(1'b1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at the terminal value while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = ZERO;
    end else if (en_i) begin
      if (cnt_q == TC_VAL) begin
        cnt_d = ZERO;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i & ~clr_i & (cnt_q == TC_VAL);

endmodule

// File: rtl/bit_stream_gen.sv
// Parallel-load, MSB-first serialiser feeding the sequence detector's x input,
// with one-shot/loop playback and a start/busy/done handshake.
module bit_stream_gen
  import bsg_pkg::*;
#(
  parameter int unsigned WIDTH = BSG_WIDTH,
  parameter int unsigned DIV   = BSG_DIV,
  parameter int unsigned LEN_W = BSG_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             x,
  output logic             x_step,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IW       = bsg_cw(WIDTH);
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);
  localparam logic [IW-1:0]    IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]    IDX_ONE  = IW'(1'b1);

  bsg_state_e       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IW-1:0]    last_idx_q, last_idx_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             loop_q, loop_d;
  logic             stop_pend_q, stop_pend_d;
  logic             x_q, x_d;
  logic             x_step_q, x_step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] eff_len_s;
  logic [IW-1:0]    last_idx_s;
  logic             stop_any_s;
  logic             div_clr_s;
  logic             div_en_s;
  logic             tick_s;

  // A zero or oversized length plays the full pattern width.
  assign eff_len_s  = ((len == LEN_ZERO) || (len > WIDTH_L)) ? WIDTH_L : len;
  assign last_idx_s = IW'(eff_len_s - LEN_ONE);
  // A stop raised in the final cycle of a bit period still ends that period.
  assign stop_any_s = stop_pend_q | stop;

  assign div_en_s  = (state_q == ST_SHIFT);
  assign div_clr_s = (state_q != ST_SHIFT);

  bit_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (div_clr_s),
    .en_i  (div_en_s),
    .tc_o  (tick_s)
  );

  // Next-state and registered-output logic for the playback FSM.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    x_d         = x_q;
    x_step_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        x_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d     = ST_SHIFT;
          pat_d       = pattern;
          last_idx_d  = last_idx_s;
          idx_d       = last_idx_s;
          loop_d      = loop;
          stop_pend_d = 1'b0;
          x_d         = pattern[last_idx_s];
          x_step_d    = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        stop_pend_d = stop_any_s;
        if (tick_s) begin
          if (stop_any_s || ((idx_q == IDX_ZERO) && !loop_q)) begin
            state_d     = ST_DONE;
            idx_d       = IDX_ZERO;
            stop_pend_d = 1'b0;
            x_d         = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else if (idx_q == IDX_ZERO) begin
            idx_d    = last_idx_q;
            x_d      = pat_q[last_idx_q];
            x_step_d = 1'b1;
          end else begin
            idx_d    = idx_q - IDX_ONE;
            x_d      = pat_q[idx_q - IDX_ONE];
            x_step_d = 1'b1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        x_d     = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        idx_d       = IDX_ZERO;
        stop_pend_d = 1'b0;
        x_d         = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pat_q       <= {WIDTH{1'b0}};
      last_idx_q  <= IDX_ZERO;
      idx_q       <= IDX_ZERO;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      x_q         <= 1'b0;
      x_step_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      last_idx_q  <= last_idx_d;
      idx_q       <= idx_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      x_q         <= x_d;
      x_step_q    <= x_step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x      = x_q;
  assign x_step = x_step_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bit_stream_gen.sv
// Directed bench for bit_stream_gen: three instances (DIV=1, 4, 2) share the
// data inputs and each has its own start; outputs are checked every cycle.
module tb_bit_stream_gen;

  logic        clk;
  logic        reset;
  logic        stop;
  logic        loop;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        st1, st4, st2;
  logic        x1, xs1, b1, d1;
  logic        x4, xs4, b4, d4;
  logic        x2, xs2, b2, d2;
  logic [15:0] pv;
  int          n_cmp;
  int          n_err;

  bit_stream_gen #(.WIDTH(16), .DIV(1), .LEN_W(5)) u_div1 (
    .clk(clk), .reset(reset), .start(st1), .stop(stop), .loop(loop),
    .pattern(pattern), .len(len), .x(x1), .x_step(xs1), .busy(b1), .done(d1)
  );

  bit_stream_gen #(.WIDTH(16), .DIV(4), .LEN_W(5)) u_div4 (
    .clk(clk), .reset(reset), .start(st4), .stop(stop), .loop(loop),
    .pattern(pattern), .len(len), .x(x4), .x_step(xs4), .busy(b4), .done(d4)
  );

  bit_stream_gen #(.WIDTH(16), .DIV(2), .LEN_W(5)) u_div2 (
    .clk(clk), .reset(reset), .start(st2), .stop(stop), .loop(loop),
    .pattern(pattern), .len(len), .x(x2), .x_step(xs2), .busy(b2), .done(d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {x, x_step, busy, done} against the expected tuple.
  task automatic chk(input string tag, input logic ox, input logic oxs,
                     input logic ob, input logic od, input logic ex,
                     input logic exs, input logic eb, input logic ed);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {ox, oxs, ob, od};
    exp = {ex, exs, eb, ed};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed x/step/busy/done=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    stop    = 1'b0;
    loop    = 1'b0;
    pattern = 16'h0000;
    len     = 5'd0;
    st1     = 1'b0;
    st4     = 1'b0;
    st2     = 1'b0;
    pv      = 16'h0000;

    repeat (2) cyc();
    chk("rst_div1", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_div4", x4, xs4, b4, d4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_div2", x2, xs2, b2, d2, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();

    // One-shot 10101 at DIV=1.
    pattern = 16'h0015; len = 5'd5; loop = 1'b0; pv = 16'h0015;
    st1 = 1'b1; cyc(); st1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("oneshot_bit%0d", k), x1, xs1, b1, d1, pv[5-k], 1'b1, 1'b1, 1'b0);
      cyc();
    end
    chk("oneshot_done", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("oneshot_idle", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bit hold 110 at DIV=4.
    pattern = 16'h0006; len = 5'd3;
    st4 = 1'b1; cyc(); st4 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("hold_c%0d", k), x4, xs4, b4, d4, (k <= 8), ((k % 4) == 1), 1'b1, 1'b0);
      cyc();
    end
    chk("hold_done", x4, xs4, b4, d4, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();

    // Loop 10 at DIV=1, then stop while the second '1' is on x.
    pattern = 16'h0002; len = 5'd2; loop = 1'b1;
    st1 = 1'b1; cyc(); st1 = 1'b0; loop = 1'b0;
    chk("loop_c1", x1, xs1, b1, d1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("loop_c2", x1, xs1, b1, d1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    stop = 1'b1;
    chk("loop_c3", x1, xs1, b1, d1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    stop = 1'b0;
    chk("loop_stop_done", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("loop_after1", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("loop_after2", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Length clamp: len=0 then len=31 both play all 16 bits of 8001.
    for (int rep = 0; rep < 2; rep++) begin
      pattern = 16'h8001;
      len     = (rep == 0) ? 5'd0 : 5'd31;
      st1 = 1'b1; cyc(); st1 = 1'b0;
      for (int k = 1; k <= 16; k++) begin
        chk($sformatf("clamp%0d_c%0d", rep, k), x1, xs1, b1, d1,
            ((k == 1) || (k == 16)), 1'b1, 1'b1, 1'b0);
        cyc();
      end
      chk($sformatf("clamp%0d_done", rep), x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc();
    end

    // Ignored start at DIV=2: second start in T+3 with new pattern/len.
    pattern = 16'h000B; len = 5'd4; pv = 16'h000B;
    st2 = 1'b1; cyc(); st2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        st2 = 1'b1; pattern = 16'h0004; len = 5'd2;
      end else begin
        st2 = 1'b0;
      end
      chk($sformatf("ign_c%0d", k), x2, xs2, b2, d2, pv[3-((k-1)/2)], ((k % 2) == 1), 1'b1, 1'b0);
      cyc();
    end
    chk("ign_done", x2, xs2, b2, d2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("ign_after1", x2, xs2, b2, d2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("ign_after2", x2, xs2, b2, d2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-run at DIV=1, then a clean replay.
    pattern = 16'h00A5; len = 5'd8; pv = 16'h00A5;
    st1 = 1'b1; cyc(); st1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("rst_run_c%0d", k), x1, xs1, b1, d1, pv[8-k], 1'b1, 1'b1, 1'b0);
      cyc();
    end
    reset = 1'b1;
    #1;
    chk("rst_async", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("rst_held", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();
    chk("rst_nodone", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);
    st1 = 1'b1; cyc(); st1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("replay_c%0d", k), x1, xs1, b1, d1, pv[8-k], 1'b1, 1'b1, 1'b0);
      cyc();
    end
    chk("replay_done", x1, xs1, b1, d1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
